// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control bundle layout, NOP encoding,
// the hard-wired zero register, and a writeback-match helper used by the
// bypass muxes of the ID/EX register and by the hazard logic.
package pipeline_pkg;

    localparam int CTRL_W        = 10;

    // Control bundle bit map
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_LO = 4;   // ALUOp[3:0] occupies bits 7:4
    localparam int CTRL_ALUOP_HI = 7;
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_MEMTOREG = 9;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0]        REG_ZERO = 5'd0;

    // True when a writeback to wreg must replace the value read for sreg.
    // Register 0 is never bypassed: writes to it are discarded.
    function automatic logic reg_match(input logic       wen,
                                       input logic [4:0] wreg,
                                       input logic [4:0] sreg);
        return wen && (wreg == sreg) && (sreg != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Ports:
//   ex_valid, ex_memread, ex_rt : instruction currently in EX
//   id_valid, id_rs, id_rt      : instruction currently in ID
//   id_uses_rt                  : ID instruction actually reads rt
//   load_use                    : ID needs a value EX is still loading
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    assign load_use = ex_valid && ex_memread && (ex_rt != REG_ZERO) && id_valid &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush/hold handling and a saturating stall counter.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   id_*                                : decoded instruction and regfile read data
//   wb_EnableWrite/write_reg/write_data : writeback port into the register file
//   flush, ex_hold                      : kill ID instruction / freeze EX register
//   stall_out                           : hold PC and IF/ID (combinational)
//   ex_*                                : registered instruction presented to EX
//   stall_cnt                           : saturating count of stalled cycles
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [XLEN-1:0]   id_rs_data,
    input  logic [XLEN-1:0]   id_rt_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_EnableWrite,
    input  logic [4:0]        wb_write_reg,
    input  logic [XLEN-1:0]   wb_write_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rs_data,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipeline_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              vld_p1;
    logic [4:0]        rs_p1, rt_p1, rd_p1;
    logic [XLEN-1:0]   rs_data_p1, rt_data_p1, imm_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              load_use;
    logic [XLEN-1:0]   rs_byp_p0, rt_byp_p0;

    hazard_detect u_hazard (
        .ex_valid   (vld_p1),
        .ex_memread (ctrl_p1[CTRL_MEMREAD]),
        .ex_rt      (rt_p1),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    // Flush kills the ID instruction, so nothing upstream needs to wait.
    assign stall_out = !flush && (ex_hold || load_use);

    // ---- p0: regfile read data, patched by the same-cycle writeback ----
    // The regfile write lands at the same edge we capture, so its read port
    // still shows the stale value.
    assign rs_byp_p0 = reg_match(wb_EnableWrite, wb_write_reg, id_rs) ? wb_write_data : id_rs_data;
    assign rt_byp_p0 = reg_match(wb_EnableWrite, wb_write_reg, id_rt) ? wb_write_data : id_rt_data;

    // ---- p1: EX register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rs_p1      <= REG_ZERO;
            rt_p1      <= REG_ZERO;
            rd_p1      <= REG_ZERO;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            ctrl_p1    <= CTRL_NOP;
            cnt_p1     <= '0;
        end else begin
            if (stall_out) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end

            if (flush || (!ex_hold && load_use)) begin
                // Bubble: a NOP with all data fields cleared
                vld_p1     <= 1'b0;
                rs_p1      <= REG_ZERO;
                rt_p1      <= REG_ZERO;
                rd_p1      <= REG_ZERO;
                rs_data_p1 <= '0;
                rt_data_p1 <= '0;
                imm_p1     <= '0;
                ctrl_p1    <= CTRL_NOP;
            end else if (ex_hold) begin
                // Frozen instruction must not miss a writeback to its sources
                if (reg_match(wb_EnableWrite, wb_write_reg, rs_p1)) begin
                    rs_data_p1 <= wb_write_data;
                end
                if (reg_match(wb_EnableWrite, wb_write_reg, rt_p1)) begin
                    rt_data_p1 <= wb_write_data;
                end
            end else begin
                vld_p1     <= id_valid;
                rs_p1      <= id_rs;
                rt_p1      <= id_rt;
                rd_p1      <= id_rd;
                rs_data_p1 <= rs_byp_p0;
                rt_data_p1 <= rt_byp_p0;
                imm_p1     <= id_imm;
                ctrl_p1    <= id_valid ? id_ctrl : CTRL_NOP;
            end
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_rs      = rs_p1;
    assign ex_rt      = rt_p1;
    assign ex_rd      = rd_p1;
    assign ex_rs_data = rs_data_p1;
    assign ex_rt_data = rt_data_p1;
    assign ex_imm     = imm_p1;
    assign ex_ctrl    = ctrl_p1;
    assign stall_cnt  = cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a reference model feeding a scoreboard.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 4;

    localparam logic [CTRL_W-1:0] C_RW = 10'b00_0000_0001;   // RegWrite
    localparam logic [CTRL_W-1:0] C_LD = 10'b10_0000_0011;   // RegWrite|MemRead|MemToReg

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rt;
    logic [XLEN-1:0]   id_rs_data, id_rt_data, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_EnableWrite;
    logic [4:0]        wb_write_reg;
    logic [XLEN-1:0]   wb_write_data;
    logic              flush, ex_hold;
    logic              stall_out;
    logic              ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [XLEN-1:0]   ex_rs_data, ex_rt_data, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_EnableWrite(wb_EnableWrite),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic              v;
        logic [4:0]        rs, rt, rd;
        logic [XLEN-1:0]   rsd, rtd, imm;
        logic [CTRL_W-1:0] ctrl;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;          // reference model of the EX register
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] byp(input logic [4:0] sreg, input logic [XLEN-1:0] rdata);
        if (wb_EnableWrite && wb_write_reg == sreg && sreg != 5'd0) return wb_write_data;
        return rdata;
    endfunction

    // One clock: check stall_out, predict the next EX state, compare after the edge.
    task automatic step(input string tag);
        exp_t nx;
        exp_t got;
        logic lu, so;
        #1;
        lu = m.v && m.ctrl[1] && (m.rt != 5'd0) && id_valid &&
             ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
        so = !flush && (ex_hold || lu);
        chk({tag, ".stall_out"}, 64'(stall_out), 64'(so));

        nx = m;
        if (reset) begin
            nx = '{v:0, rs:0, rt:0, rd:0, rsd:0, rtd:0, imm:0, ctrl:0, cnt:0};
        end else begin
            if (so && nx.cnt != {CNT_W{1'b1}}) nx.cnt = nx.cnt + 1'b1;
            if (flush || (!ex_hold && lu)) begin
                nx.v = 0; nx.rs = 0; nx.rt = 0; nx.rd = 0;
                nx.rsd = 0; nx.rtd = 0; nx.imm = 0; nx.ctrl = 0;
            end else if (ex_hold) begin
                if (wb_EnableWrite && wb_write_reg == m.rs && m.rs != 0) nx.rsd = wb_write_data;
                if (wb_EnableWrite && wb_write_reg == m.rt && m.rt != 0) nx.rtd = wb_write_data;
            end else begin
                nx.v = id_valid; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
                nx.rsd = byp(id_rs, id_rs_data);
                nx.rtd = byp(id_rt, id_rt_data);
                nx.imm = id_imm;
                nx.ctrl = id_valid ? id_ctrl : '0;
            end
        end
        m = nx;
        sb.push_back(nx);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".ex_valid"},   64'(ex_valid),   64'(got.v));
        chk({tag, ".ex_rs"},      64'(ex_rs),      64'(got.rs));
        chk({tag, ".ex_rt"},      64'(ex_rt),      64'(got.rt));
        chk({tag, ".ex_rd"},      64'(ex_rd),      64'(got.rd));
        chk({tag, ".ex_rs_data"}, 64'(ex_rs_data), 64'(got.rsd));
        chk({tag, ".ex_rt_data"}, 64'(ex_rt_data), 64'(got.rtd));
        chk({tag, ".ex_imm"},     64'(ex_imm),     64'(got.imm));
        chk({tag, ".ex_ctrl"},    64'(ex_ctrl),    64'(got.ctrl));
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'(got.cnt));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [XLEN-1:0] rsd,
                          input logic [XLEN-1:0] rtd, input logic [XLEN-1:0] imm,
                          input logic [CTRL_W-1:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [XLEN-1:0] d);
        wb_EnableWrite = en; wb_write_reg = r; wb_write_data = d;
    endtask

    initial begin
        m = '{v:0, rs:0, rt:0, rd:0, rsd:0, rtd:0, imm:0, ctrl:0, cnt:0};
        reset = 1; flush = 0; ex_hold = 0; id_uses_rt = 1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        @(posedge clk);
        step("reset");
        reset = 0;

        // Basic capture
        set_id(1, 19, 20, 3, 5, 20, 7, C_RW);
        step("capture");
        chk("capture.rs_data_lit", 64'(ex_rs_data), 64'd5);
        chk("capture.rt_data_lit", 64'(ex_rt_data), 64'd20);

        // Same-cycle writeback bypass, then register 0 never bypassed
        set_id(1, 21, 22, 4, 40, 41, 1, C_RW);
        set_wb(1, 21, 99);
        step("bypass");
        chk("bypass.lit", 64'(ex_rs_data), 64'd99);
        set_id(1, 0, 22, 4, 40, 41, 1, C_RW);
        set_wb(1, 0, 99);
        step("bypass_r0");
        chk("bypass_r0.lit", 64'(ex_rs_data), 64'd40);
        set_wb(0, 0, 0);

        // Load-use: load to r20, dependent instruction reads r20
        set_id(1, 1, 20, 20, 0, 0, 8, C_LD);
        step("load");
        set_id(1, 20, 9, 10, 11, 12, 13, C_RW);
        step("lu_bubble");
        chk("lu_bubble.ctrl_lit", 64'(ex_ctrl), 64'd0);
        step("lu_capture");
        chk("lu_capture.cnt_lit", 64'(stall_cnt), 64'd1);

        // Idle slot: id_valid=0 must yield a NOP ctrl
        set_id(0, 2, 3, 4, 5, 6, 7, C_LD);
        step("idle");

        // Hold for three cycles with a writeback to the held rt in the middle
        set_id(1, 18, 19, 5, 17, 7, 2, C_RW);
        step("pre_hold");
        ex_hold = 1;
        set_id(1, 6, 7, 8, 1, 2, 3, C_RW);
        step("hold1");
        set_wb(1, 19, 123);
        step("hold2");
        set_wb(0, 0, 0);
        step("hold3");
        chk("hold.rt_data_lit", 64'(ex_rt_data), 64'd123);
        chk("hold.cnt_lit", 64'(stall_cnt), 64'd4);
        ex_hold = 0;

        // Flush beats hold and load-use
        set_id(1, 1, 5, 5, 0, 0, 0, C_LD);
        step("load2");
        set_id(1, 5, 5, 9, 1, 1, 1, C_RW);
        flush = 1; ex_hold = 1;
        step("flush");
        flush = 0; ex_hold = 0;

        // Reset while holding discards the held instruction
        set_id(1, 11, 12, 13, 14, 15, 16, C_RW);
        step("pre_rst");
        ex_hold = 1;
        step("hold_rst");
        reset = 1;
        step("rst_in_hold");
        reset = 0;

        // Counter saturation
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat.cnt_lit", 64'(stall_cnt), 64'd15);
        ex_hold = 0;
        step("release");

        if (sb.size() != 0) chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
